// File: rtl/ecc_scalar_mult_ctrl.sv
// ecc_scalar_mult_ctrl: left-to-right double-and-add sequencer for Q = m*P.
// Issues LOAD/DBL/ADD commands to the shared point unit and tracks whether Q is at infinity.
module ecc_scalar_mult_ctrl #(
  parameter int MAX_BITS = 256,
  parameter int IDX_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [1:0]          i_mode,
  input  logic [MAX_BITS-1:0] i_m,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_inf,
  output logic                o_op_valid,
  output logic [1:0]          o_op_code,
  input  logic                i_op_ready,
  input  logic                i_op_done,
  input  logic                i_op_inf
);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, NEXT, FIN} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_DBL  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;

  state_t              state;
  logic [MAX_BITS-1:0] m_q;
  logic [IDX_W-1:0]    idx;
  logic                q_inf;
  logic                bit_cur;

  function automatic logic [MAX_BITS-1:0] width_mask(input logic [1:0] mode);
    width_mask = {MAX_BITS{1'b1}} >> (MAX_BITS - (32 << mode));
  endfunction

  function automatic logic [IDX_W-1:0] top_index(input logic [1:0] mode);
    top_index = IDX_W'((32 << mode) - 1);
  endfunction

  assign bit_cur = m_q[idx];

  // Scalar is pure data: captured on an accepted start, never reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && i_start) begin
      m_q <= i_m & width_mask(i_mode);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      q_inf      <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_inf      <= 1'b0;
      o_op_valid <= 1'b0;
      o_op_code  <= OP_LOAD;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            idx    <= top_index(i_mode);
            q_inf  <= 1'b1;
            o_busy <= 1'b1;
            o_inf  <= 1'b0;
            state  <= SCAN;
          end
        end
        // While Q is still infinity a set bit means LOAD, never ADD.
        SCAN: begin
          if (bit_cur) begin
            o_op_code  <= OP_LOAD;
            o_op_valid <= 1'b1;
            state      <= ISSUE;
          end else if (idx == '0) begin
            o_inf  <= q_inf;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= FIN;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        ISSUE: begin
          if (i_op_ready) begin
            o_op_valid <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (i_op_done) begin
            q_inf <= i_op_inf;
            state <= NEXT;
          end
        end
        // A DBL on a set bit is followed by the add step; everything else
        // moves to the next bit, skipping the DBL while Q is infinity.
        NEXT: begin
          if (o_op_code == OP_DBL && bit_cur) begin
            o_op_code  <= q_inf ? OP_LOAD : OP_ADD;
            o_op_valid <= 1'b1;
            state      <= ISSUE;
          end else if (idx == '0) begin
            o_inf  <= q_inf;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= FIN;
          end else begin
            idx <= idx - 1'b1;
            if (q_inf) begin
              state <= SCAN;
            end else begin
              o_op_code  <= OP_DBL;
              o_op_valid <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        FIN: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
